// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the result display: converter FSM states,
// active-low segment patterns (gfedcba) and BCD accumulator sizing.
package seg_disp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        COMMIT = 2'd3
    } conv_state_e;

    localparam int BCD_DIGITS = 5;
    localparam int ACC_W      = 4 * BCD_DIGITS;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Entry [d] is the pattern for decimal digit d.
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        if (d > 4'd9) begin
            return SEG_BLANK;
        end
        return SEG_DIGIT[d];
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one LOAD cycle, WIDTH SHIFT cycles, one COMMIT cycle.
// src_o holds the value captured at LOAD so the parent can detect input changes.
module bin2bcd_seq
    import seg_disp_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] src_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [ACC_W-1:0] bcd_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    conv_state_e      state_q, state_d;
    logic [WIDTH-1:0] src_q, src_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [3:0]       nib;
    logic             carry_unused;

    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            shreg_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        adj = acc_q;
        nib = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            nib = acc_q[4*i +: 4];
            if (nib >= 4'd5) begin
                adj[4*i +: 4] = nib + 4'd3;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        shreg_d      = shreg_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        carry_unused = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                src_d   = bin_i;
                shreg_d = bin_i;
                acc_d   = '0;
                cnt_d   = '0;
                busy_d  = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                // The top BCD bit can never carry out for inputs below 10^5.
                {carry_unused, acc_d, shreg_d} = {adj, shreg_q, 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign src_o  = src_q;
    assign busy_o = busy_q;
    assign done_o = (state_q == COMMIT);
    assign bcd_o  = acc_q;

endmodule

// File: rtl/result_seg_display.sv
// 4-digit multiplexed common-anode display of a binary result: change-detect, BCD conversion,
// leading-zero blanking, overflow dashes and a free-running digit scan.
module result_seg_display
    import seg_disp_pkg::*;
#(
    parameter int WIDTH        = 14,
    parameter int REFRESH_BITS = 16,
    parameter int BLANK_LEAD   = 1
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic [WIDTH-1:0] value,
    output logic [3:0]       an,
    output logic [6:0]       seg,
    output logic             dp,
    output logic             ovf,
    output logic             busy
);

    logic [WIDTH-1:0]        captured;
    logic                    conv_start;
    logic                    conv_done;
    logic [ACC_W-1:0]        conv_bcd;

    logic [15:0]             shown_q, shown_d;
    logic                    ovf_q, ovf_d;
    logic [REFRESH_BITS-1:0] scan_q, scan_d;
    logic [1:0]              idx_q, idx_d;
    logic [3:0]              an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic [15:0]             upper;
    logic [3:0]              digit;

    assign conv_start = (value != captured);

    bin2bcd_seq #(
        .WIDTH (WIDTH)
    ) u_conv (
        .mclk    (mclk),
        .reset   (reset),
        .start_i (conv_start),
        .bin_i   (value),
        .src_o   (captured),
        .busy_o  (busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    always_ff @(posedge mclk) begin
        if (reset) begin
            shown_q <= '0;
            ovf_q   <= 1'b0;
            scan_q  <= '0;
            idx_q   <= '0;
            an_q    <= 4'b1111;
            seg_q   <= SEG_BLANK;
        end else begin
            shown_q <= shown_d;
            ovf_q   <= ovf_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    // Outputs are registered from next-state values so they stay glitch-free
    // without adding a cycle of latency behind the commit.
    always_comb begin
        shown_d = shown_q;
        ovf_d   = ovf_q;
        if (conv_done) begin
            shown_d = conv_bcd[15:0];
            ovf_d   = |conv_bcd[ACC_W-1:16];
        end

        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (&scan_q) begin
            idx_d = idx_q + 2'd1;
        end

        an_d  = ~(4'b0001 << idx_d);
        digit = shown_d[4*idx_d +: 4];
        upper = shown_d >> {idx_d, 2'b00};

        if (ovf_d) begin
            seg_d = SEG_DASH;
        end else if ((BLANK_LEAD != 0) && (idx_d != 2'd0) && (upper == 16'd0)) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_of(digit);
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign ovf = ovf_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_result_seg_display.sv
// Randomised self-checking bench for result_seg_display against a decimal-arithmetic display model.
module tb_result_seg_display;

    logic        mclk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] value = '0;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1, ovf0, ovf1, busy0, busy1;

    int tests = 0;
    int fails = 0;
    int k = 0;
    int shown_v = 0;

    result_seg_display #(.WIDTH(14), .REFRESH_BITS(4), .BLANK_LEAD(1)) u_dut_blank (
        .mclk(mclk), .reset(reset), .value(value),
        .an(an0), .seg(seg0), .dp(dp0), .ovf(ovf0), .busy(busy0)
    );

    result_seg_display #(.WIDTH(14), .REFRESH_BITS(4), .BLANK_LEAD(0)) u_dut_full (
        .mclk(mclk), .reset(reset), .value(value),
        .an(an1), .seg(seg1), .dp(dp1), .ovf(ovf1), .busy(busy1)
    );

    always #5 mclk = ~mclk;

    // Edges since reset release; the scan index follows directly from it.
    always @(posedge mclk) k <= reset ? 0 : k + 1;

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int idx, input bit bl);
        int p10 [4] = '{1, 10, 100, 1000};
        if (v > 9999) return 7'h3F;
        if (bl && idx > 0 && v < p10[idx]) return 7'h7F;
        return pat((v / p10[idx]) % 10);
    endfunction

    function automatic int exp_idx();
        return (k / 16) % 4;
    endfunction

    function automatic logic [3:0] exp_an();
        logic [3:0] one = 4'b0001;
        return ~(one << exp_idx());
    endfunction

    task automatic settle(input int v);
        value = 14'(v);
        repeat (17) @(posedge mclk);
        @(negedge mclk);
        shown_v = v;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        value = '0;
        repeat (2) @(posedge mclk);
        @(negedge mclk);
        reset = 1'b0;
        value = 14'd1234;
        repeat (5) @(posedge mclk);
        @(negedge mclk);
        tests++;
        if (busy0 !== 1'b1) begin
            fails++;
            $display("FAIL reset_pre_busy: busy=%b expected 1", busy0);
        end
        reset = 1'b1;
        value = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge mclk);
            @(negedge mclk);
            tests++;
            if (an0 !== 4'hF || an1 !== 4'hF || seg0 !== 7'h7F || seg1 !== 7'h7F ||
                busy0 !== 1'b0 || ovf0 !== 1'b0 || dp0 !== 1'b1) begin
                fails++;
                $display("FAIL reset_hold: an=%b/%b seg=%h/%h busy=%b ovf=%b dp=%b expected 1111 7f 0 0 1",
                         an0, an1, seg0, seg1, busy0, ovf0, dp0);
            end
        end
        reset = 1'b0;
        shown_v = 0;
        @(posedge mclk);
        @(negedge mclk);
        tests++;
        if (an0 !== 4'b1110 || seg0 !== 7'h40 || seg1 !== 7'h40 || busy0 !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: an=%b seg=%h/%h busy=%b expected 1110 40/40 0", an0, seg0, seg1, busy0);
        end
        repeat (4) begin
            @(posedge mclk);
            @(negedge mclk);
            tests++;
            if (busy0 !== 1'b0 || dp1 !== 1'b1) begin
                fails++;
                $display("FAIL reset_idle: busy=%b dp=%b expected 0 1", busy0, dp1);
            end
        end
    endtask

    task automatic test_convert();
        logic [3:0] seen = '0;
        value = 14'd1234;
        for (int i = 0; i <= 16; i++) begin
            @(posedge mclk);
            @(negedge mclk);
            tests++;
            if (busy0 !== ((i >= 1 && i <= 15) ? 1'b1 : 1'b0)) begin
                fails++;
                $display("FAIL convert_busy edge %0d: busy=%b", i, busy0);
            end
            if (i == 15) begin
                tests++;
                if (seg0 !== exp_seg(0, exp_idx(), 1'b1)) begin
                    fails++;
                    $display("FAIL convert_early: seg=%h expected %h", seg0, exp_seg(0, exp_idx(), 1'b1));
                end
            end
            if (i == 16) begin
                tests++;
                if (seg0 !== exp_seg(1234, exp_idx(), 1'b1) || ovf0 !== 1'b0) begin
                    fails++;
                    $display("FAIL convert_latency: seg=%h ovf=%b expected %h 0",
                             seg0, ovf0, exp_seg(1234, exp_idx(), 1'b1));
                end
            end
        end
        shown_v = 1234;
        for (int c = 0; c < 64; c++) begin
            @(posedge mclk);
            @(negedge mclk);
            seen |= ~an0;
            tests++;
            if (an0 !== exp_an() || seg0 !== exp_seg(1234, exp_idx(), 1'b1)) begin
                fails++;
                $display("FAIL convert_scan: an=%b seg=%h expected %b %h",
                         an0, seg0, exp_an(), exp_seg(1234, exp_idx(), 1'b1));
            end
        end
        tests++;
        if (seen !== 4'hF) begin
            fails++;
            $display("FAIL convert_all_digits: seen=%b expected 1111", seen);
        end
    endtask

    task automatic test_scan();
        for (int c = 0; c < 80; c++) begin
            @(posedge mclk);
            @(negedge mclk);
            tests++;
            if (an0 !== exp_an() || an1 !== exp_an() ||
                seg0 !== exp_seg(shown_v, exp_idx(), 1'b1) || seg1 !== exp_seg(shown_v, exp_idx(), 1'b0)) begin
                fails++;
                $display("FAIL scan k=%0d: an=%b/%b seg=%h/%h expected an %b", k, an0, an1, seg0, seg1, exp_an());
            end
        end
    endtask

    task automatic test_overflow();
        settle(16383);
        tests++;
        if (ovf0 !== 1'b1 || ovf1 !== 1'b1 || busy0 !== 1'b0) begin
            fails++;
            $display("FAIL ovf_set: ovf=%b/%b busy=%b expected 1 1 0", ovf0, ovf1, busy0);
        end
        for (int c = 0; c < 64; c++) begin
            @(posedge mclk);
            @(negedge mclk);
            tests++;
            if (seg0 !== 7'h3F || seg1 !== 7'h3F || an0 !== exp_an()) begin
                fails++;
                $display("FAIL ovf_dash: seg=%h/%h an=%b expected 3f %b", seg0, seg1, an0, exp_an());
            end
        end
        settle(9999);
        tests++;
        if (ovf0 !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear: ovf=%b expected 0", ovf0);
        end
        for (int c = 0; c < 64; c++) begin
            @(posedge mclk);
            @(negedge mclk);
            tests++;
            if (seg0 !== 7'h10 || seg1 !== 7'h10) begin
                fails++;
                $display("FAIL nines: seg=%h/%h expected 10", seg0, seg1);
            end
        end
    endtask

    task automatic test_blanking();
        logic [6:0] e0, e1;
        settle(7);
        for (int c = 0; c < 64; c++) begin
            @(posedge mclk);
            @(negedge mclk);
            e0 = (exp_idx() == 0) ? 7'h78 : 7'h7F;
            e1 = (exp_idx() == 0) ? 7'h78 : 7'h40;
            tests++;
            if (seg0 !== e0 || seg1 !== e1 || an0 !== exp_an() || an1 !== exp_an()) begin
                fails++;
                $display("FAIL blanking idx=%0d: seg=%h/%h an=%b/%b expected %h/%h %b",
                         exp_idx(), seg0, seg1, an0, an1, e0, e1, exp_an());
            end
        end
    endtask

    task automatic test_midchange();
        value = 14'd254;
        for (int i = 0; i <= 33; i++) begin
            @(posedge mclk);
            @(negedge mclk);
            if (i == 4) value = 14'd16129;
            if (i == 16 || i == 32) begin
                tests++;
                if (ovf0 !== 1'b0 || seg0 !== exp_seg(254, exp_idx(), 1'b1)) begin
                    fails++;
                    $display("FAIL mid_first edge %0d: ovf=%b seg=%h expected 0 %h",
                             i, ovf0, seg0, exp_seg(254, exp_idx(), 1'b1));
                end
            end
            if (i == 17 || i == 18) begin
                tests++;
                if (busy0 !== ((i == 18) ? 1'b1 : 1'b0)) begin
                    fails++;
                    $display("FAIL mid_restart edge %0d: busy=%b", i, busy0);
                end
            end
            if (i == 33) begin
                tests++;
                if (ovf0 !== 1'b1 || seg0 !== 7'h3F || busy0 !== 1'b0) begin
                    fails++;
                    $display("FAIL mid_final: ovf=%b seg=%h busy=%b expected 1 3f 0", ovf0, seg0, busy0);
                end
            end
        end
        shown_v = 16129;
    endtask

    task automatic test_random();
        int v;
        for (int n = 0; n < 8; n++) begin
            v = (n % 2 == 1) ? int'($urandom_range(16383, 10000)) : int'($urandom_range(9999, 0));
            settle(v);
            tests++;
            if (ovf0 !== ((v > 9999) ? 1'b1 : 1'b0) || busy0 !== 1'b0) begin
                fails++;
                $display("FAIL rand_ovf v=%0d: ovf=%b busy=%b", v, ovf0, busy0);
            end
            for (int c = 0; c < 40; c++) begin
                @(posedge mclk);
                @(negedge mclk);
                tests++;
                if (seg0 !== exp_seg(v, exp_idx(), 1'b1) || seg1 !== exp_seg(v, exp_idx(), 1'b0) ||
                    an0 !== exp_an()) begin
                    fails++;
                    $display("FAIL rand_disp v=%0d idx=%0d: seg=%h/%h an=%b expected %h/%h %b",
                             v, exp_idx(), seg0, seg1, an0,
                             exp_seg(v, exp_idx(), 1'b1), exp_seg(v, exp_idx(), 1'b0), exp_an());
                end
            end
        end
    endtask

    initial begin
        @(negedge mclk);
        test_reset();
        test_convert();
        test_scan();
        test_overflow();
        test_blanking();
        test_midchange();
        test_scan();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
